// File: rtl/if_stage_prefetch_if.sv
// Fetch-stage bus bundle: instruction SRAM request/response,
// branch redirect input and the IF->ID valid/allowin handshake.
interface if_stage_prefetch_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_adef;

  modport master (
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    input  br_taken,
    input  br_target,
    input  id_allowin,
    output if_to_id_valid,
    output if_inst,
    output if_pc,
    output if_adef
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    output br_taken,
    output br_target,
    output id_allowin,
    input  if_to_id_valid,
    input  if_inst,
    input  if_pc,
    input  if_adef
  );
endinterface

// File: rtl/if_stage_prefetch.sv
// Prefetching IF stage: sequential fetch from a 1-cycle SRAM into a
// FIFO of {pc, inst, adef}, flushed on redirect, with a fault marker
// for misaligned targets. Ports: clk, reset (sync, active-high), bus.
module if_stage_prefetch #(
  parameter logic [31:0] RESET_PC    = 32'h1C00_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input logic                clk,
  input logic                reset,
  if_stage_prefetch_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [31:0]     fetch_pc;
  logic [31:0]     inflight_pc;
  logic [31:0]     tgt;
  logic [31:0]     req_addr;
  logic            inflight;
  logic            discard;
  logic            halted;
  logic            halted_next;
  logic            misalign;
  logic            room;
  logic            issue;
  logic            push;
  logic            pop;
  logic            valid;

  assign misalign = CHECK_ALIGN && bus.br_taken
                    && (bus.br_target[1:0] != 2'b00);

  assign tgt = CHECK_ALIGN ? bus.br_target
                           : {bus.br_target[31:2], 2'b00};

  assign req_addr = bus.br_taken ? tgt : fetch_pc;

  // Slots already promised: buffered entries plus the one in flight.
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};

  // A redirect flushes everything, so there is always room for it.
  assign room = bus.br_taken
                || (occ < (CW+1)'(FIFO_DEPTH));

  assign halted_next = bus.br_taken ? misalign : halted;

  assign issue = !reset && !halted_next && room;

  // The response belonging to a request made before a redirect
  // arrives in the redirect cycle itself and is dropped there.
  assign push = inflight && !discard && !bus.br_taken;

  assign valid = (count != '0);
  assign pop   = valid && bus.id_allowin && !bus.br_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      discard     <= 1'b0;
      halted      <= 1'b0;
      count       <= '0;
      rptr        <= '0;
      wptr        <= '0;
    end else begin
      halted   <= halted_next;
      inflight <= issue;
      discard  <= bus.br_taken && inflight && !issue;
      if (issue) begin
        fetch_pc    <= req_addr + 32'd4;
        inflight_pc <= req_addr;
      end
      if (bus.br_taken) begin
        rptr  <= '0;
        wptr  <= PW'(misalign);
        count <= CW'(misalign);
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (misalign) begin
        mem[0] <= '{pc: bus.br_target, inst: 32'd0, adef: 1'b1};
      end else if (push) begin
        mem[wptr] <= '{pc: inflight_pc,
                       inst: bus.inst_sram_rdata,
                       adef: 1'b0};
      end
    end
  end

  assign head = mem[rptr];

  assign bus.inst_sram_en    = issue;
  assign bus.inst_sram_we    = 4'h0;
  assign bus.inst_sram_addr  = req_addr;
  assign bus.inst_sram_wdata = 32'd0;

  assign bus.if_to_id_valid = valid;
  assign bus.if_inst = valid ? head.inst : 32'd0;
  assign bus.if_pc   = valid ? head.pc   : 32'd0;
  assign bus.if_adef = valid && head.adef;

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch with a 1-cycle SRAM model.
// Inputs driven and outputs checked just after each falling edge.
module tb_if_stage_prefetch;
  localparam logic [31:0] RP = 32'h1C00_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  if_stage_prefetch_if bus();

  if_stage_prefetch #(
    .RESET_PC(RP),
    .FIFO_DEPTH(4),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk)
    if (bus.inst_sram_en)
      bus.inst_sram_rdata <= word(bus.inst_sram_addr);

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // Two reset cycles; returns at the first free-running cycle.
  task automatic rst_seq(logic allow);
    reset = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 32'd0;
    bus.id_allowin = allow;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic [19:0] pat;
  int          pops;

  initial begin
    reset = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 32'd0;
    bus.id_allowin = 1'b1;
    nxt();
    nxt();
    settle();
    chk("rst_en", 32'(bus.inst_sram_en), 0);
    chk("rst_valid", 32'(bus.if_to_id_valid), 0);
    chk("rst_inst", bus.if_inst, 0);
    chk("rst_pc", bus.if_pc, 0);
    chk("rst_adef", 32'(bus.if_adef), 0);
    chk("rst_we", 32'(bus.inst_sram_we), 0);

    // Streaming with id_allowin held high
    reset = 1'b0;
    settle();
    chk("t1_en0", 32'(bus.inst_sram_en), 1);
    chk("t1_a0", bus.inst_sram_addr, RP);
    chk("t1_v0", 32'(bus.if_to_id_valid), 0);
    nxt(); settle();
    chk("t1_a1", bus.inst_sram_addr, RP + 4);
    chk("t1_v1", 32'(bus.if_to_id_valid), 0);
    nxt(); settle();
    chk("t1_a2", bus.inst_sram_addr, RP + 8);
    chk("t1_v2", 32'(bus.if_to_id_valid), 1);
    chk("t1_pc2", bus.if_pc, RP);
    chk("t1_in2", bus.if_inst, word(RP));
    nxt(); settle();
    chk("t1_pc3", bus.if_pc, RP + 4);
    nxt(); settle();
    chk("t1_pc4", bus.if_pc, RP + 8);
    chk("t1_in4", bus.if_inst, word(RP + 8));

    // Fill to full with id_allowin low, then drain
    rst_seq(1'b0);
    settle();
    chk("t2_a1", bus.inst_sram_addr, RP);
    nxt(); settle();
    chk("t2_a2", bus.inst_sram_addr, RP + 4);
    nxt(); settle();
    chk("t2_a3", bus.inst_sram_addr, RP + 8);
    nxt(); settle();
    chk("t2_en4", 32'(bus.inst_sram_en), 1);
    chk("t2_a4", bus.inst_sram_addr, RP + 12);
    nxt(); settle();
    chk("t2_en5", 32'(bus.inst_sram_en), 0);
    chk("t2_pc5", bus.if_pc, RP);
    nxt(); settle();
    chk("t2_en6", 32'(bus.inst_sram_en), 0);
    nxt();
    bus.id_allowin = 1'b1;
    settle();
    chk("t2_en7", 32'(bus.inst_sram_en), 0);
    chk("t2_pc7", bus.if_pc, RP);
    nxt(); settle();
    chk("t2_en8", 32'(bus.inst_sram_en), 1);
    chk("t2_a8", bus.inst_sram_addr, RP + 32'h10);
    chk("t2_pc8", bus.if_pc, RP + 4);
    nxt(); settle();
    chk("t2_pc9", bus.if_pc, RP + 8);
    nxt(); settle();
    chk("t2_pc10", bus.if_pc, RP + 12);
    nxt(); settle();
    chk("t2_pc11", bus.if_pc, RP + 32'h10);
    chk("t2_in11", bus.if_inst, word(RP + 32'h10));

    // Redirect with 2 buffered + 1 in flight
    rst_seq(1'b0);
    nxt(); nxt(); nxt();
    bus.br_taken = 1'b1;
    bus.br_target = RP + 32'h100;
    settle();
    chk("t3_en", 32'(bus.inst_sram_en), 1);
    chk("t3_a", bus.inst_sram_addr, RP + 32'h100);
    nxt();
    bus.br_taken = 1'b0;
    settle();
    chk("t3_v", 32'(bus.if_to_id_valid), 0);
    chk("t3_a1", bus.inst_sram_addr, RP + 32'h104);
    nxt(); settle();
    chk("t3_v2", 32'(bus.if_to_id_valid), 1);
    chk("t3_pc", bus.if_pc, RP + 32'h100);
    chk("t3_in", bus.if_inst, word(RP + 32'h100));

    // Misaligned target: fault entry and halt
    nxt();
    bus.br_taken = 1'b1;
    bus.br_target = RP + 32'h102;
    settle();
    chk("t4_en0", 32'(bus.inst_sram_en), 0);
    nxt();
    bus.br_taken = 1'b0;
    bus.id_allowin = 1'b1;
    settle();
    chk("t4_v", 32'(bus.if_to_id_valid), 1);
    chk("t4_adef", 32'(bus.if_adef), 1);
    chk("t4_pc", bus.if_pc, RP + 32'h102);
    chk("t4_inst", bus.if_inst, 0);
    chk("t4_en1", 32'(bus.inst_sram_en), 0);
    nxt();
    bus.id_allowin = 1'b0;
    settle();
    chk("t4_v2", 32'(bus.if_to_id_valid), 0);
    chk("t4_en2", 32'(bus.inst_sram_en), 0);
    nxt(); settle();
    chk("t4_en3", 32'(bus.inst_sram_en), 0);
    nxt();
    bus.br_taken = 1'b1;
    bus.br_target = RP + 32'h200;
    settle();
    chk("t4_en4", 32'(bus.inst_sram_en), 1);
    chk("t4_a4", bus.inst_sram_addr, RP + 32'h200);
    nxt();
    bus.br_taken = 1'b0;
    settle();
    chk("t4_a5", bus.inst_sram_addr, RP + 32'h204);
    nxt(); settle();
    chk("t4_pc6", bus.if_pc, RP + 32'h200);
    chk("t4_adef6", 32'(bus.if_adef), 0);

    // Reset with 3 buffered + 1 in flight
    rst_seq(1'b0);
    nxt(); nxt(); nxt(); nxt();
    reset = 1'b1;
    settle();
    chk("t5_en", 32'(bus.inst_sram_en), 0);
    nxt();
    reset = 1'b0;
    settle();
    chk("t5_v", 32'(bus.if_to_id_valid), 0);
    chk("t5_a", bus.inst_sram_addr, RP);
    nxt(); settle();
    chk("t5_v1", 32'(bus.if_to_id_valid), 0);
    nxt(); settle();
    chk("t5_pc", bus.if_pc, RP);

    // Full FIFO, irregular pops across pointer wrap
    rst_seq(1'b0);
    nxt(); nxt(); nxt(); nxt(); nxt();
    settle();
    chk("t6_pc0", bus.if_pc, RP);
    exp_pc = RP;
    pops = 0;
    pat = 20'b1011_0111_1101_1110_1111;
    for (int i = 0; i < 20; i++) begin
      nxt();
      bus.id_allowin = pat[i];
      settle();
      if (bus.if_to_id_valid) begin
        chk("t6_pc", bus.if_pc, exp_pc);
        chk("t6_in", bus.if_inst, word(exp_pc));
        if (pat[i]) begin
          exp_pc = exp_pc + 4;
          pops++;
        end
      end
    end
    chk("t6_pops", 32'(pops >= 10), 1);

    // PC wrap at top of address space
    nxt();
    bus.id_allowin = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 32'hFFFF_FFF8;
    settle();
    chk("t7_a0", bus.inst_sram_addr, 32'hFFFF_FFF8);
    nxt();
    bus.br_taken = 1'b0;
    settle();
    chk("t7_a1", bus.inst_sram_addr, 32'hFFFF_FFFC);
    nxt(); settle();
    chk("t7_a2", bus.inst_sram_addr, 32'h0);
    chk("t7_pc", bus.if_pc, 32'hFFFF_FFF8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
